ul_deframer: RTL and testbench
==============================

Name: ul_deframer

Overview:
- Uplink receive stage. Consumes the external serial uplink pair (ul_in/ul_en) and deserializes it into bytes in a local buffer.
- Checks length and a CRC-8 trailer for each frame.
- Forwards valid payload bytes to the shared UART TX path through its second write port (wr1/wdata1, req[1]/grant[1]), which is tied off today.
- It is the uplink counterpart of the downlink serializer and shares the same serial clock divider register.

Parameters:
- MDW, 8, byte width; equals the UART data width.
- BUF_DEPTH, 16, maximum frame length in bytes, CRC byte included. Must be a power of 2.
- SERIAL_DIV_WIDTH, 8, width of ser_clk_div.
- CRC_POLY, 8'h07, CRC-8 polynomial. Init 0x00, MSB-first, no reflection, no final XOR.
- SYNC_STAGES, 2, synchronizer flop count for ul_in and ul_en.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, block enable. When low, the FSM is held in IDLE.
- ul_in, in, 1, serial uplink data, MSB first.
- ul_en, in, 1, frame envelope. High for the whole frame.
- ser_clk_div, in, SERIAL_DIV_WIDTH, bit period equals ser_clk_div+1 clk cycles.
- uart_req, out, 1, request for the UART TX port (goes to req[1]).
- uart_grant, in, 1, UART TX grant (from grant[1]).
- uart_tx_full, in, 1, UART TX FIFO full.
- uart_wr, out, 1, byte write strobe (goes to wr1).
- uart_wdata, out, MDW, byte data (goes to wdata1).
- busy, out, 1, FSM is not in IDLE.
- frm_ok, out, 1, one-cycle pulse: frame fully forwarded.
- crc_err, out, 1, one-cycle pulse: CRC mismatch, frame dropped.
- len_err, out, 1, one-cycle pulse: bit count not a multiple of 8, or fewer than 2 bytes.
- ovf_err, out, 1, one-cycle pulse: frame longer than BUF_DEPTH bytes.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, all counters, the CRC register and the synchronizers are 0. Buffer contents are don't-care.
- Synchronization:
  - ul_in and ul_en each pass through SYNC_STAGES flops.
  - Edges of ul_en are detected on the synchronized copy.
- Bit timing:
  - A rising edge in IDLE with enable=1 loads the bit counter with ser_clk_div>>1.
  - The counter decrements each cycle. At 0 the block samples ul_in and reloads ser_clk_div, giving mid-bit sampling.
  - ser_clk_div=0 samples every cycle.
- Assembly:
  - Each sample shifts into an MSB-first byte shift register and updates the CRC serially (crc = {crc[6:0],0} ^ (CRC_POLY if crc[7]^bit)).
  - Every 8th bit writes the byte to buf[wr_ptr] and increments wr_ptr. The counter is 5 bits wide.
- FSM states:
  - IDLE → RECV on ul_en rise with enable=1.
  - RECV → CHECK on ul_en fall.
  - RECV → DROP on byte count > BUF_DEPTH. ovf_err pulses at that moment.
  - CHECK lasts 1 cycle:
    - bits==0: return to IDLE silently, no pulse.
    - bits%8≠0 or bytes<2: len_err, go to IDLE.
    - crc≠0: crc_err, go to IDLE. The CRC is run over the whole frame including the trailer, so a valid frame leaves a zero remainder.
    - otherwise go to REQ.
  - REQ: uart_req=1. Wait for uart_grant, then go to SEND.
  - SEND:
    - uart_req stays at 1.
    - When uart_grant=1 and uart_tx_full=0: uart_wr=1, uart_wdata=buf[rd_ptr], rd_ptr++.
    - Bytes 0..bytes-2 are sent. The CRC byte is not forwarded.
    - After the last write: frm_ok pulses, uart_req drops the next cycle, go to IDLE.
  - DROP: wait for ul_en low, then go to IDLE.
- Latency: CHECK follows the synchronized ul_en fall by 1 cycle; uart_req rises 1 cycle after CHECK.
- Boundary conditions:
  - Grant or full drops during SEND: the write stalls, with no loss and no duplicate.
  - ul_en toggles while in CHECK, REQ or SEND: ignored. A frame starting during that window is lost entirely; the block waits for a fresh rise in IDLE.
  - enable drops mid-frame: abort to IDLE, no pulse. uart_req drops the next cycle.
  - Exactly BUF_DEPTH bytes: accepted.
  - ul_en rises and falls with no sample taken: treated as bits==0.
  - rst_n asserted mid-operation: immediate reset; no partial writes follow.

Decomposition:
- Shared package fec_pkg:
  - UL_BUF_DEPTH.
  - UL_CRC_POLY.
  - typedef enum ul_state_t {IDLE, RECV, CHECK, REQ, SEND, DROP}.
- One sub-module, ul_bit_sampler: synchronizers, edge detect, bit timing counter. Outputs are sample_stb, sample_bit, en_rise and en_fall.
- Buffer, CRC and FSM live in ul_deframer.

Test Plan:
- Baseline frame: div=3, frame bytes 0x01,0x07; grant tied to req. Required: one write of 0x01, then frm_ok; crc_err/len_err stay 0.
- Two-byte payload: frame 0x01,0x02,0x1B with div=0. Required: writes 0x01 then 0x02, then frm_ok.
- Corrupted CRC: frame 0x01,0x02,0x1A. Required: crc_err pulse; no uart_req; busy returns to 0.
- Length errors:
  - 12-bit frame. Required: len_err.
  - 8-bit frame 0x00. Required: len_err.
  - 17 bytes with BUF_DEPTH=16. Required: ovf_err; no write; IDLE after ul_en falls.
- Grant and full stall: delay grant 5 cycles, then hold uart_tx_full for 3 cycles mid-SEND on a 4-byte payload. Required: exactly 4 in-order writes, with no writes while full.
- Disturbance:
  - Drop enable mid-RECV. Required: no pulses.
  - Assert rst_n mid-SEND. Required: all outputs 0 within 0 cycles.
  - Send a next frame while in REQ. Required: that frame is ignored.

Source files
------------

// File: rtl/fec_pkg.sv
// Shared definitions for the uplink deframer: buffer depth, CRC-8 polynomial,
// FSM state encoding and the serial CRC step.
package fec_pkg;

    localparam int         UL_BUF_DEPTH = 16;
    localparam logic [7:0] UL_CRC_POLY  = 8'h07;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        REQ,
        SEND,
        DROP
    } ul_state_t;

    // One MSB-first CRC-8 step for a single received bit
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din,
                                             input logic [7:0] poly);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/ul_bit_sampler.sv
// Uplink synchronizers, envelope edge detection and mid-bit sample timing.
module ul_bit_sampler #(
    parameter int SERIAL_DIV_WIDTH = 8,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ul_in,
    input  logic                        ul_en,
    input  logic [SERIAL_DIV_WIDTH-1:0] ser_clk_div,
    input  logic                        start,
    input  logic                        run,
    output logic                        sample_stb,
    output logic                        sample_bit,
    output logic                        en_rise,
    output logic                        en_fall
);

    logic [SYNC_STAGES-1:0]      in_sync;
    logic [SYNC_STAGES-1:0]      en_sync;
    logic                        in_d;
    logic                        en_d;
    logic [SERIAL_DIV_WIDTH-1:0] bit_tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sync <= '0;
            en_sync <= '0;
            in_d    <= 1'b0;
            en_d    <= 1'b0;
            bit_tmr <= '0;
        end else begin
            in_sync <= {in_sync[SYNC_STAGES-2:0], ul_in};
            en_sync <= {en_sync[SYNC_STAGES-2:0], ul_en};
            // data gets the same extra stage as the edge detector so bit 0 lines up with en_rise
            in_d    <= in_sync[SYNC_STAGES-1];
            en_d    <= en_sync[SYNC_STAGES-1];
            if (start)
                bit_tmr <= ser_clk_div >> 1;
            else if (run)
                bit_tmr <= (bit_tmr == '0) ? ser_clk_div : bit_tmr - 1'b1;
        end
    end

    assign en_rise    =  en_sync[SYNC_STAGES-1] & ~en_d;
    assign en_fall    = ~en_sync[SYNC_STAGES-1] &  en_d;
    assign sample_stb = run && (bit_tmr == '0);
    assign sample_bit = in_d;

endmodule

// File: rtl/ul_deframer.sv
// Uplink receive stage: deserializes framed bytes, checks length and CRC-8,
// and forwards the payload through the second UART TX write port.
module ul_deframer
    import fec_pkg::*;
#(
    parameter int         MDW              = 8,
    parameter int         BUF_DEPTH        = UL_BUF_DEPTH,
    parameter int         SERIAL_DIV_WIDTH = 8,
    parameter logic [7:0] CRC_POLY         = UL_CRC_POLY,
    parameter int         SYNC_STAGES      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        ul_in,
    input  logic                        ul_en,
    input  logic [SERIAL_DIV_WIDTH-1:0] ser_clk_div,
    output logic                        uart_req,
    input  logic                        uart_grant,
    input  logic                        uart_tx_full,
    output logic                        uart_wr,
    output logic [MDW-1:0]              uart_wdata,
    output logic                        busy,
    output logic                        frm_ok,
    output logic                        crc_err,
    output logic                        len_err,
    output logic                        ovf_err
);

    localparam int             AW      = $clog2(BUF_DEPTH);
    localparam int             PW      = AW + 1;
    localparam int             BCW     = $clog2(MDW);
    localparam logic [PW-1:0]  DEPTH_P = PW'(BUF_DEPTH);

    ul_state_t        state, next_state;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [BCW-1:0]   bit_cnt;
    logic [MDW-1:0]   shreg;
    logic [7:0]       crc;
    logic [MDW-1:0]   buf_mem [BUF_DEPTH];

    logic             sample_stb, sample_bit, en_rise, en_fall;
    logic             start, byte_done, buf_we;
    logic [MDW-1:0]   shreg_next;

    ul_bit_sampler #(
        .SERIAL_DIV_WIDTH(SERIAL_DIV_WIDTH),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .ul_in      (ul_in),
        .ul_en      (ul_en),
        .ser_clk_div(ser_clk_div),
        .start      (start),
        .run        (state == RECV),
        .sample_stb (sample_stb),
        .sample_bit (sample_bit),
        .en_rise    (en_rise),
        .en_fall    (en_fall)
    );

    assign shreg_next = {shreg[MDW-2:0], sample_bit};
    assign byte_done  = sample_stb && (bit_cnt == BCW'(MDW-1));

    always_comb begin
        next_state = state;
        start      = 1'b0;
        buf_we     = 1'b0;
        uart_req   = 1'b0;
        uart_wr    = 1'b0;
        frm_ok     = 1'b0;
        crc_err    = 1'b0;
        len_err    = 1'b0;
        ovf_err    = 1'b0;
        case (state)
            IDLE: begin
                if (en_rise) begin
                    start      = 1'b1;
                    next_state = RECV;
                end
            end
            RECV: begin
                if (byte_done && wr_ptr == DEPTH_P) begin
                    ovf_err    = 1'b1;
                    next_state = en_fall ? IDLE : DROP;
                end else begin
                    buf_we = byte_done;
                    if (en_fall)
                        next_state = CHECK;
                end
            end
            CHECK: begin
                next_state = IDLE;
                if (bit_cnt == '0 && wr_ptr == '0)
                    next_state = IDLE;
                else if (bit_cnt != '0 || wr_ptr < PW'(2))
                    len_err = 1'b1;
                else if (crc != '0)
                    crc_err = 1'b1;
                else
                    next_state = REQ;
            end
            REQ: begin
                uart_req = 1'b1;
                if (uart_grant)
                    next_state = SEND;
            end
            SEND: begin
                uart_req = 1'b1;
                if (uart_grant && !uart_tx_full) begin
                    uart_wr = 1'b1;
                    // trailer sits at wr_ptr-1 and is never forwarded
                    if (rd_ptr == wr_ptr - PW'(2)) begin
                        frm_ok     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            DROP: begin
                if (en_fall)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (!enable) begin
            next_state = IDLE;
            start      = 1'b0;
            buf_we     = 1'b0;
            uart_wr    = 1'b0;
            frm_ok     = 1'b0;
            crc_err    = 1'b0;
            len_err    = 1'b0;
            ovf_err    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            crc     <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                bit_cnt <= '0;
                shreg   <= '0;
                crc     <= '0;
            end else if (sample_stb) begin
                shreg   <= shreg_next;
                crc     <= crc8_step(crc, sample_bit, CRC_POLY);
                bit_cnt <= bit_cnt + 1'b1;
                if (buf_we)
                    wr_ptr <= wr_ptr + 1'b1;
            end
            if (uart_wr)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we)
            buf_mem[wr_ptr[AW-1:0]] <= shreg_next;
    end

    assign uart_wdata = uart_wr ? buf_mem[rd_ptr[AW-1:0]] : '0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ul_deframer.sv
// Directed bench for ul_deframer with a byte scoreboard on the UART write port.
module tb_ul_deframer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n, enable, ul_in, ul_en, uart_tx_full;
    logic [7:0] div;
    logic       uart_req, uart_grant, uart_wr, busy, frm_ok, crc_err, len_err, ovf_err;
    logic [7:0] uart_wdata;
    logic       tie_grant, man_grant;

    int n_vec = 0;
    int n_err = 0;
    int cnt_wr, cnt_frm, cnt_crc, cnt_len, cnt_ovf, cnt_req;
    logic [7:0] exp_q[$];
    logic [7:0] frame_q[$];

    always #5 clk = ~clk;
    assign uart_grant = tie_grant ? uart_req : man_grant;

    ul_deframer #(
        .MDW(8), .BUF_DEPTH(DEPTH), .SERIAL_DIV_WIDTH(8), .CRC_POLY(8'h07), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ul_in(ul_in), .ul_en(ul_en),
        .ser_clk_div(div), .uart_req(uart_req), .uart_grant(uart_grant),
        .uart_tx_full(uart_tx_full), .uart_wr(uart_wr), .uart_wdata(uart_wdata),
        .busy(busy), .frm_ok(frm_ok), .crc_err(crc_err), .len_err(len_err), .ovf_err(ovf_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: pops the scoreboard and tallies pulses
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n === 1'b1) begin
            if (uart_wr === 1'b1) begin
                cnt_wr++;
                n_vec++;
                assert (uart_tx_full === 1'b0) else begin
                    n_err++;
                    $error("FAIL wr_while_full: observed full=%0b expected 0", uart_tx_full);
                end
                n_vec++;
                assert (exp_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_wr: observed data %0h expected no write", uart_wdata);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    assert (uart_wdata === e) else begin
                        n_err++;
                        $error("FAIL wdata: observed %0h expected %0h", uart_wdata, e);
                    end
                end
            end
            if (frm_ok === 1'b1)   cnt_frm++;
            if (crc_err === 1'b1)  cnt_crc++;
            if (len_err === 1'b1)  cnt_len++;
            if (ovf_err === 1'b1)  cnt_ovf++;
            if (uart_req === 1'b1) cnt_req++;
        end
    end

    task automatic clr();
        cnt_wr = 0; cnt_frm = 0; cnt_crc = 0; cnt_len = 0; cnt_ovf = 0; cnt_req = 0;
    endtask

    // Byte-wise CRC-8 (poly 0x07) over the first n bytes of frame_q
    function automatic logic [7:0] crc8_of(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = c ^ frame_q[i];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    task automatic build_frame(input int n, input logic [7:0] seed, input bit push_exp);
        logic [7:0] b;
        frame_q.delete();
        for (int i = 0; i < n; i++) begin
            b = seed + 8'(i * 29);
            frame_q.push_back(b);
            if (push_exp) exp_q.push_back(b);
        end
        frame_q.push_back(crc8_of(n));
    endtask

    task automatic send_frame(input int nbits);
        logic [7:0] b;
        for (int i = 0; i < nbits; i++) begin
            b     = frame_q[i / 8];
            ul_en = 1'b1;
            ul_in = b[7 - (i % 8)];
            repeat (int'(div) + 1) @(posedge clk);
            #1;
        end
        ul_en = 1'b0;
        ul_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_idle"}, 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (uart_req !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_req"}, 32'(uart_req), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_counts(input string tag, input int frm, input int ce, input int le,
                                 input int oe, input int wr);
        check({tag, "_frm"}, cnt_frm, frm);
        check({tag, "_crc"}, cnt_crc, ce);
        check({tag, "_len"}, cnt_len, le);
        check({tag, "_ovf"}, cnt_ovf, oe);
        check({tag, "_wr"},  cnt_wr,  wr);
        check({tag, "_sb"},  exp_q.size(), 0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; enable = 1'b0; ul_in = 1'b0; ul_en = 1'b0; div = 8'd3;
        tie_grant = 1'b1; man_grant = 1'b0; uart_tx_full = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        check("reset", {17'd0, uart_req, uart_wr, uart_wdata, busy, frm_ok, crc_err, len_err, ovf_err}, 0);
        rst_n = 1'b1; enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Baseline 0x01 + CRC 0x07
        clr(); div = 8'd3;
        frame_q.delete(); frame_q.push_back(8'h01); frame_q.push_back(8'h07);
        exp_q.push_back(8'h01);
        send_frame(16); wait_idle("base");
        expect_counts("base", 1, 0, 0, 0, 1);

        // Two-byte payload, one cycle per bit
        clr(); div = 8'd0;
        frame_q.delete(); frame_q.push_back(8'h01); frame_q.push_back(8'h02); frame_q.push_back(8'h1B);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        send_frame(24); wait_idle("two");
        expect_counts("two", 1, 0, 0, 0, 2);

        // Corrupted trailer
        clr(); div = 8'd2;
        frame_q.delete(); frame_q.push_back(8'h01); frame_q.push_back(8'h02); frame_q.push_back(8'h1A);
        send_frame(24); wait_idle("crcbad");
        expect_counts("crcbad", 0, 1, 0, 0, 0);
        check("crcbad_req", cnt_req, 0);

        // 12-bit frame
        clr(); div = 8'd1;
        frame_q.delete(); frame_q.push_back(8'hAB); frame_q.push_back(8'hC0);
        send_frame(12); wait_idle("len12");
        expect_counts("len12", 0, 0, 1, 0, 0);

        // Single byte frame
        clr();
        frame_q.delete(); frame_q.push_back(8'h00);
        send_frame(8); wait_idle("len8");
        expect_counts("len8", 0, 0, 1, 0, 0);

        // 17 bytes overflows
        clr();
        build_frame(DEPTH, 8'h21, 1'b0);
        send_frame(8 * (DEPTH + 1)); wait_idle("ovf");
        expect_counts("ovf", 0, 0, 0, 1, 0);
        check("ovf_req", cnt_req, 0);

        // Exactly BUF_DEPTH bytes is accepted
        clr();
        build_frame(DEPTH - 1, 8'h11, 1'b1);
        send_frame(8 * DEPTH); wait_idle("full16");
        expect_counts("full16", 1, 0, 0, 0, DEPTH - 1);

        // Grant delay then full stall mid-SEND
        clr(); div = 8'd0; tie_grant = 1'b0; man_grant = 1'b0;
        build_frame(4, 8'hC3, 1'b1);
        send_frame(40); wait_req("stall");
        repeat (5) @(posedge clk);
        #1;
        check("stall_nowr", cnt_wr, 0);
        man_grant = 1'b1;
        k = 0;
        while (cnt_wr == 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        uart_tx_full = 1'b1;
        check("stall_first", cnt_wr, 1);
        repeat (3) @(posedge clk);
        #1;
        check("stall_hold", cnt_wr, 1);
        uart_tx_full = 1'b0;
        wait_idle("stall");
        expect_counts("stall", 1, 0, 0, 0, 4);
        man_grant = 1'b0;

        // Enable drops mid-RECV
        clr(); div = 8'd2; tie_grant = 1'b1;
        build_frame(2, 8'h77, 1'b0);
        fork
            send_frame(24);
            begin
                repeat (15) @(posedge clk);
                #1;
                enable = 1'b0;
            end
        join
        enable = 1'b1;
        wait_idle("endrop");
        expect_counts("endrop", 0, 0, 0, 0, 0);

        // Envelope too short for any sample
        clr(); div = 8'd7;
        ul_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ul_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("nosamp_busy", 32'(busy), 1);
        wait_idle("nosamp");
        expect_counts("nosamp", 0, 0, 0, 0, 0);

        // Second frame arriving during REQ is ignored
        clr(); div = 8'd0; tie_grant = 1'b0; man_grant = 1'b0;
        build_frame(1, 8'h5A, 1'b1);
        send_frame(16); wait_req("inreq");
        build_frame(1, 8'h33, 1'b0);
        send_frame(16);
        repeat (6) @(posedge clk);
        #1;
        man_grant = 1'b1;
        wait_idle("inreq");
        repeat (10) @(posedge clk);
        #1;
        expect_counts("inreq", 1, 0, 0, 0, 1);
        check("inreq_busy", 32'(busy), 0);

        // Reset while stalled in SEND
        clr(); man_grant = 1'b1; uart_tx_full = 1'b1;
        build_frame(3, 8'h40, 1'b0);
        send_frame(32); wait_req("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_outs", {17'd0, uart_req, uart_wr, uart_wdata, busy, frm_ok, crc_err, len_err, ovf_err}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; uart_tx_full = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_nowr", cnt_wr, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frm", cnt_frm, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
